uart_tx_packet_arbiter: RTL and testbench

Shares one byte-wide `uart_tx` instance between two packet sources (requester 0: slave-bound command path; requester 1: host-bound response path). Captures a whole packet from the granted requester, serialises it byte by byte through the `uart_tx` load/start/finish handshake, and reports completion or failure. Sits between the host-side command sequencer and the BLE or host `uart_tx` instance, replacing per-path byte loops in the top-level FSM.

---
 rtl/uart_tx_packet_arbiter.sv | 233 +++++++++++++++++++++++
 tb/tb_uart_tx_packet_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_packet_arbiter.sv
// uart_tx_packet_arbiter
// Round-robin arbiter that shares one byte-wide uart_tx between two packet
// sources. A granted packet is captured whole, then sent one byte at a time
// through the uart_tx load / start / finish handshake. Completion is reported
// with a done pulse. Illegal lengths and stalled handshakes are reported with
// an error pulse.

module uart_tx_packet_arbiter #(
  parameter int PACKET_BITS = 144,
  parameter int MAX_BYTES   = 18,
  parameter int HOLD_CYCLES = 5208,
  parameter int TIMEOUT     = 4000000
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   req0_valid,
  input  logic                   req1_valid,
  input  logic [PACKET_BITS-1:0] req0_data,
  input  logic [PACKET_BITS-1:0] req1_data,
  input  logic [4:0]             req0_len,
  input  logic [4:0]             req1_len,
  output logic                   req0_ack,
  output logic                   req1_ack,
  output logic                   req0_done,
  output logic                   req1_done,
  output logic                   error,
  output logic                   busy,
  output logic                   grant_id,
  output logic [7:0]             uart_data,
  output logic                   uart_load_data,
  output logic                   uart_start_transmit,
  input  logic                   uart_tx_finish
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES) + 1;
  localparam int TO_W   = $clog2(TIMEOUT) + 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);
  localparam logic [4:0]        LEN_MAX   = 5'(MAX_BYTES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAPTURE,
    S_LOAD,
    S_START,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic                   fin_meta, fin_s;
  logic                   last_ptr_q;
  logic                   grant_q;
  logic [PACKET_BITS-1:0] pkt_q;
  logic [4:0]             len_q;
  logic [4:0]             idx_q;
  logic                   load_on_q;
  logic                   abort_q;
  logic [7:0]             data_q;
  logic [HOLD_W-1:0]      hold_cnt_q;
  logic [TO_W-1:0]        to_cnt_q;

  logic                   winner;
  logic [4:0]             sel_len;
  logic                   len_bad;
  logic                   hold_end;
  logic                   timeout_hit;
  logic                   load_begin;
  logic                   to_abort;

  // Bring the baud-domain finish level into the clk domain.
  // NOTE: every clocked register uses <= so all flops sample pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fin_meta <= 1'b0;
      fin_s    <= 1'b0;
    end else begin
      fin_meta <= uart_tx_finish;
      fin_s    <= fin_meta;
    end
  end

  // Arbitration and length legality of the requester being captured.
  always_comb begin
    // NOTE: defaults first so no path through this block can infer a latch.
    winner = 1'b0;
    if (req0_valid && req1_valid) winner = ~last_ptr_q;
    else                          winner = req1_valid;
    sel_len     = grant_q ? req1_len : req0_len;
    len_bad     = (sel_len == 5'd0) || (sel_len > LEN_MAX);
    hold_end    = (hold_cnt_q == HOLD_LAST);
    timeout_hit = (to_cnt_q == TO_LAST);
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    state_d             = state_q;
    load_begin          = 1'b0;
    to_abort            = 1'b0;
    req0_ack            = 1'b0;
    req1_ack            = 1'b0;
    req0_done           = 1'b0;
    req1_done           = 1'b0;
    error               = 1'b0;
    busy                = 1'b0;
    uart_load_data      = 1'b0;
    uart_start_transmit = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req0_valid || req1_valid) state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        busy     = 1'b1;
        req0_ack = ~grant_q;
        req1_ack = grant_q;
        error    = len_bad;
        state_d  = len_bad ? S_IDLE : S_LOAD;
      end
      S_LOAD: begin
        busy           = 1'b1;
        uart_load_data = load_on_q;
        if (load_on_q) begin
          if (hold_end) begin
            state_d = S_START;
          end else if (timeout_hit) begin
            state_d  = S_DONE;
            to_abort = 1'b1;
          end
        end else if (fin_s) begin
          load_begin = 1'b1;
        end else if (timeout_hit) begin
          state_d  = S_DONE;
          to_abort = 1'b1;
        end
      end
      S_START: begin
        busy                = 1'b1;
        uart_start_transmit = 1'b1;
        if (hold_end) state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        busy = 1'b1;
        if (!fin_s) begin
          state_d = S_WAIT_DONE;
        end else if (timeout_hit) begin
          state_d  = S_DONE;
          to_abort = 1'b1;
        end
      end
      S_WAIT_DONE: begin
        busy = 1'b1;
        if (fin_s) begin
          state_d = ((idx_q + 5'd1) == len_q) ? S_DONE : S_LOAD;
        end else if (timeout_hit) begin
          state_d  = S_DONE;
          to_abort = 1'b1;
        end
      end
      S_DONE: begin
        req0_done = ~grant_q;
        req1_done = grant_q;
        error     = abort_q;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign grant_id  = grant_q;
  assign uart_data = data_q;

  // State register; a reset mid-packet simply returns to IDLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Grant and last-served pointer; pointer starts at 1 so requester 0 wins first.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_ptr_q <= 1'b1;
      grant_q    <= 1'b0;
    end else if (state_q == S_IDLE && (req0_valid || req1_valid)) begin
      last_ptr_q <= winner;
      grant_q    <= winner;
    end
  end

  // Packet capture from the granted requester.
  // NOTE: payload/length are pure datapath, always written before use, so no reset.
  always_ff @(posedge clk) begin
    if (state_q == S_CAPTURE) begin
      pkt_q <= grant_q ? req1_data : req0_data;
      len_q <= sel_len;
    end
  end

  // Byte index, abort flag, load phase and the byte presented to uart_tx.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_q     <= 5'd0;
      abort_q   <= 1'b0;
      load_on_q <= 1'b0;
      data_q    <= 8'd0;
    end else begin
      if (state_q == S_CAPTURE)             idx_q <= 5'd0;
      else if (state_q == S_WAIT_DONE && fin_s) idx_q <= idx_q + 5'd1;

      if (state_q == S_CAPTURE) abort_q <= 1'b0;
      else if (to_abort)        abort_q <= 1'b1;

      load_on_q <= (state_q == S_LOAD) && (state_d == S_LOAD) && (load_on_q || load_begin);

      if (load_begin) data_q <= 8'(pkt_q >> {idx_q, 3'b000});
    end
  end

  // Strobe hold counter and per-state timeout counter; both saturate.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_cnt_q <= '0;
      to_cnt_q   <= '0;
    end else begin
      if (load_begin || (state_d != state_q)) hold_cnt_q <= HOLD_W'(1);
      else if (!hold_end)                     hold_cnt_q <= hold_cnt_q + HOLD_W'(1);

      if (state_d != state_q) to_cnt_q <= '0;
      else if (!timeout_hit)  to_cnt_q <= to_cnt_q + TO_W'(1);
    end
  end

endmodule

// File: tb/tb_uart_tx_packet_arbiter.sv
// Testbench for uart_tx_packet_arbiter: behavioural uart_tx, randomized and
// directed packets, and a scoreboard of expected ack / byte / done events.

module tb_uart_tx_packet_arbiter;

  localparam int PB      = 144;
  localparam int MAXB    = 18;
  localparam int HOLD    = 4;
  localparam int TIMEOUT = 64;

  localparam logic [1:0] K_ACK  = 2'd1;
  localparam logic [1:0] K_BYTE = 2'd2;
  localparam logic [1:0] K_DONE = 2'd3;

  typedef struct packed {
    logic [1:0] kind;
    logic       id;
    logic       err;
    logic [7:0] data;
  } ev_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          req0_valid, req1_valid;
  logic [PB-1:0] req0_data, req1_data;
  logic [4:0]    req0_len, req1_len;
  logic          req0_ack, req1_ack, req0_done, req1_done;
  logic          error, busy, grant_id;
  logic [7:0]    uart_data;
  logic          uart_load_data, uart_start_transmit;
  logic          uart_tx_finish = 1'b1;

  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  ev_t sb[$];
  bit  model_last = 1'b1;
  int  byte_cnt = 0;
  int  ack_cyc_at[2];
  int  done_cyc_at[2];
  int  last_start_cyc = 0;
  bit  uart_stuck = 1'b0;

  uart_tx_packet_arbiter #(
    .PACKET_BITS(PB), .MAX_BYTES(MAXB), .HOLD_CYCLES(HOLD), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_data(req0_data), .req1_data(req1_data),
    .req0_len(req0_len), .req1_len(req1_len),
    .req0_ack(req0_ack), .req1_ack(req1_ack),
    .req0_done(req0_done), .req1_done(req1_done),
    .error(error), .busy(busy), .grant_id(grant_id),
    .uart_data(uart_data), .uart_load_data(uart_load_data),
    .uart_start_transmit(uart_start_transmit), .uart_tx_finish(uart_tx_finish)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic ev_t mk_ev(logic [1:0] kind, logic id, logic err, logic [7:0] data);
    ev_t e;
    e.kind = kind; e.id = id; e.err = err; e.data = data;
    return e;
  endfunction

  function automatic logic [31:0] out_vec();
    return 32'({req0_ack, req1_ack, req0_done, req1_done, error, busy, grant_id,
                uart_load_data, uart_start_transmit, uart_data});
  endfunction

  function automatic logic [PB-1:0] rand_pkt();
    logic [PB-1:0] r = '0;
    for (int i = 0; i < 5; i++) r = {r[PB-33:0], 32'($urandom())};
    return r;
  endfunction

  function automatic logic [4:0] rand_len();
    if ($urandom_range(0, 9) == 0)
      return ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom_range(19, 31));
    return 5'($urandom_range(1, MAXB));
  endfunction

  // Reference model: one packet's observable events in order.
  function automatic void expect_packet(bit id, logic [4:0] len, logic [PB-1:0] data);
    bit bad = (len == 5'd0) || (int'(len) > MAXB);
    sb.push_back(mk_ev(K_ACK, id, bad, 8'h00));
    model_last = id;
    if (!bad) begin
      for (int k = 0; k < int'(len); k++) sb.push_back(mk_ev(K_BYTE, id, 1'b0, data[8*k +: 8]));
      sb.push_back(mk_ev(K_DONE, id, 1'b0, 8'h00));
    end
  endfunction

  task automatic sb_compare(input ev_t obs);
    ev_t exp;
    if (sb.size() == 0) begin
      check("unexpected_event", 32'(obs), 32'd0);
    end else begin
      exp = sb.pop_front();
      check("event", 32'(obs), 32'(exp));
    end
  endtask

  // Behavioural uart_tx: finish drops 3 cycles after start, rises 20 cycles later.
  bit m_active = 1'b0;
  bit m_start_prev = 1'b0;
  int m_phase = 0;
  always @(negedge clk) begin
    if (uart_start_transmit && !m_start_prev && !m_active) begin
      m_active = 1'b1;
      m_phase  = 0;
    end else if (m_active) begin
      m_phase++;
      if (m_phase == 3 && !uart_stuck) uart_tx_finish = 1'b0;
      if (m_phase == 23) begin
        uart_tx_finish = 1'b1;
        m_active = 1'b0;
      end
    end
    m_start_prev = uart_start_transmit;
  end

  // Monitor: turn output pulses into events and check strobe shape.
  bit         load_prev = 1'b0, start_prev = 1'b0;
  int         load_len = 0, start_len = 0;
  logic [7:0] held = 8'h00;
  always @(negedge clk) begin
    bit any_ack, any_done;
    int diff;
    if (!reset_n) begin
      load_prev = 1'b0; start_prev = 1'b0; load_len = 0; start_len = 0;
    end else begin
      any_ack  = req0_ack | req1_ack;
      any_done = req0_done | req1_done;
      if (any_ack) begin
        sb_compare(mk_ev(K_ACK, req1_ack, error, 8'h00));
        ack_cyc_at[req1_ack] = cyc;
        if (!error) check("busy_at_ack", 32'(busy), 32'd1);
      end
      if (uart_load_data && !load_prev) begin
        sb_compare(mk_ev(K_BYTE, grant_id, error, uart_data));
        held = uart_data;
        byte_cnt++;
      end else if (uart_load_data || uart_start_transmit) begin
        check("data_stable", 32'(uart_data), 32'(held));
      end
      if (any_done) begin
        sb_compare(mk_ev(K_DONE, req1_done, error, 8'h00));
        done_cyc_at[req1_done] = cyc;
        check("busy_at_done", 32'(busy), 32'd0);
        check("strobes_at_done", 32'({uart_load_data, uart_start_transmit}), 32'd0);
        if (error) begin
          diff = cyc - last_start_cyc;
          check("timeout_window", 32'(diff >= TIMEOUT && diff <= TIMEOUT + 4), 32'd1);
        end
      end
      if (!any_ack && !any_done) check("stray_error", 32'(error), 32'd0);
      check("load_start_overlap", 32'(uart_load_data & uart_start_transmit), 32'd0);
      if (uart_load_data) load_len++;
      else if (load_prev) begin
        check("load_len", 32'(load_len), 32'(HOLD));
        load_len = 0;
      end
      if (uart_start_transmit) start_len++;
      else if (start_prev) begin
        check("start_len", 32'(start_len), 32'(HOLD));
        start_len = 0;
        last_start_cyc = cyc - 1;
      end
      load_prev  = uart_load_data;
      start_prev = uart_start_transmit;
    end
  end

  // Requester: present a packet, hold it until ack, then scramble the bus.
  task automatic send(input bit id, input logic [4:0] len, input logic [PB-1:0] data,
                      output int ack_cyc);
    int n = 0;
    bit got = 1'b0;
    if (id) begin req1_len = len; req1_data = data; req1_valid = 1'b1; end
    else    begin req0_len = len; req0_data = data; req0_valid = 1'b1; end
    ack_cyc = -1;
    while (!got && n < 20000) begin
      @(negedge clk);
      n++;
      if (id ? req1_ack : req0_ack) begin
        got = 1'b1;
        ack_cyc = cyc;
      end
    end
    if (!got) check("ack_seen", 32'(got), 32'd1);
    @(posedge clk);
    #1;
    if (id) begin req1_valid = 1'b0; req1_data = rand_pkt(); req1_len = rand_len(); end
    else    begin req0_valid = 1'b0; req0_data = rand_pkt(); req0_len = rand_len(); end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("drained", 32'({sb.size() == 0, busy}), 32'h2);
    sb.delete();
    repeat (3) @(negedge clk);
  endtask

  task automatic send_pair(input logic [4:0] l0, input logic [PB-1:0] d0,
                           input logic [4:0] l1, input logic [PB-1:0] d1);
    bit w = ~model_last;
    int a0, a1;
    expect_packet(w, w ? l1 : l0, w ? d1 : d0);
    expect_packet(~w, w ? l0 : l1, w ? d0 : d1);
    @(posedge clk);
    #1;
    fork
      send(1'b0, l0, d0, a0);
      send(1'b1, l1, d1, a1);
    join
    wait_idle();
  endtask

  initial begin
    logic [PB-1:0] d0, d1;
    logic [4:0]    l0;
    int            a, issue, base, n;
    bit            id;
    logic [4:0]    bad_lens [2];

    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_data = '0; req1_data = '0; req0_len = 5'd0; req1_len = 5'd0;
    reset_n = 1'b1;
    #3 reset_n = 1'b0;
    #2 check("reset_outputs", out_vec(), 32'd0);
    repeat (3) @(posedge clk);
    #3 reset_n = 1'b1;
    repeat (2) @(posedge clk);

    // Both requesters in the same cycle, twice.
    for (int r = 0; r < 2; r++) send_pair(5'd2, rand_pkt(), 5'd3, rand_pkt());

    // Three-byte packet from idle: byte order and ack latency.
    d0 = rand_pkt();
    d0[23:0] = 24'hCCBBAA;
    expect_packet(1'b0, 5'd3, d0);
    @(posedge clk); #1;
    issue = cyc;
    send(1'b0, 5'd3, d0, a);
    check("ack_latency", 32'(a - issue), 32'd1);
    wait_idle();

    // Illegal lengths on requester 1.
    bad_lens[0] = 5'd0;
    bad_lens[1] = 5'd19;
    for (int i = 0; i < 2; i++) begin
      expect_packet(1'b1, bad_lens[i], d0);
      @(posedge clk); #1;
      issue = cyc;
      send(1'b1, bad_lens[i], d0, a);
      check("bad_len_ack_latency", 32'(a - issue), 32'd1);
      wait_idle();
    end

    // uart_tx never goes busy: timeout abort on the first byte.
    uart_stuck = 1'b1;
    d0 = rand_pkt();
    sb.push_back(mk_ev(K_ACK, 1'b0, 1'b0, 8'h00));
    sb.push_back(mk_ev(K_BYTE, 1'b0, 1'b0, d0[7:0]));
    sb.push_back(mk_ev(K_DONE, 1'b0, 1'b1, 8'h00));
    model_last = 1'b0;
    @(posedge clk); #1;
    send(1'b0, 5'd3, d0, a);
    wait_idle();
    uart_stuck = 1'b0;
    repeat (30) @(posedge clk);

    // Requester 1 arrives while requester 0 is being served.
    d0 = rand_pkt();
    d1 = rand_pkt();
    expect_packet(1'b0, 5'd4, d0);
    expect_packet(1'b1, 5'd2, d1);
    @(posedge clk); #1;
    fork
      send(1'b0, 5'd4, d0, a);
      begin
        int a1;
        repeat (20) @(posedge clk);
        #1;
        send(1'b1, 5'd2, d1, a1);
      end
    join
    wait_idle();
    check("pending_gap", 32'(ack_cyc_at[1] - done_cyc_at[0]), 32'd2);

    // Reset during byte 2 of an 18-byte packet, then a full 18-byte packet.
    d0 = rand_pkt();
    expect_packet(1'b0, 5'd18, d0);
    @(posedge clk); #1;
    base = byte_cnt;
    send(1'b0, 5'd18, d0, a);
    n = 0;
    while (byte_cnt < base + 2 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("reached_byte2", 32'(byte_cnt >= base + 2), 32'd1);
    repeat (3) @(posedge clk);
    #3 reset_n = 1'b0;
    sb.delete();
    model_last = 1'b1;
    #1 check("reset_mid_outputs", out_vec(), 32'd0);
    repeat (3) @(posedge clk);
    #3 reset_n = 1'b1;
    repeat (2) @(posedge clk);
    d1 = rand_pkt();
    expect_packet(1'b1, 5'd18, d1);
    @(posedge clk); #1;
    send(1'b1, 5'd18, d1, a);
    wait_idle();

    // Randomized traffic.
    for (int it = 0; it < 12; it++) begin
      if ($urandom_range(0, 1) == 1) begin
        send_pair(rand_len(), rand_pkt(), rand_len(), rand_pkt());
      end else begin
        id = 1'($urandom_range(0, 1));
        l0 = rand_len();
        d0 = rand_pkt();
        expect_packet(id, l0, d0);
        @(posedge clk); #1;
        send(id, l0, d0, a);
        wait_idle();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

endmodule
